// File: rtl/ru_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ru_mem_arbiter
//
// Shares one single-port unified RAM between the instruction fetch port
// (read-only) and the load/store data port (read/write). One access is in
// flight at a time and walks IDLE -> ACCESS -> RESP -> IDLE. The data port
// wins arbitration unless fetch has already lost STARVE_MAX times in a row.
// RAM address/write data come from registers latched at grant, so they stay
// stable while the RAM reports busy. Read data and acks are registered.
//
// Ports
//   clk, rst              clock; synchronous active-high reset
//   i_req/i_addr          fetch request (level) and byte address
//   i_rdata/i_ack         fetch read data, valid with the one-cycle i_ack
//   d_ren/d_wen           data read / write request (level); both = write
//   d_addr/d_wdata        data byte address and write value
//   d_rdata/d_ack         data read value (pre-write value on a write),
//                         valid with the one-cycle d_ack
//   ram_wen/ram_addr/ram_wdata   RAM write enable, address, write data
//   ram_rdata/ram_busy    RAM combinational read data and busy flag
//   gnt_d                 current/last owner: 1 = data, 0 = fetch
// ---------------------------------------------------------------------------
module ru_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_ren,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              ram_wen,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              ram_busy,
   output logic              gnt_d
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_cnt_nxt;
   logic             wr_flag;
   logic             d_req;
   logic             grant_d;
   logic             grant_i;
   logic             complete;

   assign d_req = d_ren | d_wen;

   // The write strobe is gated by rst so an access aborted by reset never lands.
   assign ram_wen = (state == ACCESS) & wr_flag & gnt_d & ~rst;

   // State register and starvation counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= {CNT_W{1'b0}};
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_cnt_nxt;
      end
   end

   // Arbitration, next-state and starvation-counter update.
   always_comb begin
      state_nxt      = state;
      starve_cnt_nxt = starve_cnt;
      grant_d        = 1'b0;
      grant_i        = 1'b0;
      complete       = 1'b0;
      case (state)
         IDLE: begin
            // Data wins unless fetch is waiting and has lost STARVE_MAX times.
            if (d_req && ((starve_cnt < CNT_MAX) || !i_req)) begin
               grant_d   = 1'b1;
               state_nxt = ACCESS;
            end else if (i_req) begin
               grant_i   = 1'b1;
               state_nxt = ACCESS;
            end else begin
               state_nxt = IDLE;
            end
            // Count only losses suffered while fetch is actually waiting.
            if (!i_req || grant_i) begin
               starve_cnt_nxt = {CNT_W{1'b0}};
            end else if (grant_d && (starve_cnt < CNT_MAX)) begin
               starve_cnt_nxt = starve_cnt + CNT_ONE;
            end else begin
               starve_cnt_nxt = starve_cnt;
            end
         end
         ACCESS: begin
            if (!ram_busy) begin
               complete  = 1'b1;
               state_nxt = RESP;
            end else begin
               state_nxt = ACCESS;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Grant latches, read-data capture and ack pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         gnt_d     <= 1'b0;
         wr_flag   <= 1'b0;
         ram_addr  <= {ADDR_W{1'b0}};
         ram_wdata <= {DATA_W{1'b0}};
         i_rdata   <= {DATA_W{1'b0}};
         d_rdata   <= {DATA_W{1'b0}};
         i_ack     <= 1'b0;
         d_ack     <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         if (grant_d) begin
            gnt_d     <= 1'b1;
            wr_flag   <= d_wen;
            ram_addr  <= d_addr;
            ram_wdata <= d_wdata;
         end else if (grant_i) begin
            gnt_d    <= 1'b0;
            wr_flag  <= 1'b0;
            ram_addr <= i_addr;
         end
         // The ack lands in RESP; the non-owner's rdata is left untouched.
         if (complete) begin
            if (gnt_d) begin
               d_rdata <= ram_rdata;
               d_ack   <= 1'b1;
            end else begin
               i_rdata <= ram_rdata;
               i_ack   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ru_mem_arbiter.sv
// Bench for ru_mem_arbiter: directed scenarios followed by randomized traffic
// from two requesters, checked against a shadow memory updated per completed
// transaction plus arbitration/handshake properties.
module tb_ru_mem_arbiter;
   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = 32'h0;
   logic [31:0] i_rdata;
   logic        i_ack;
   logic        d_ren = 1'b0;
   logic        d_wen = 1'b0;
   logic [31:0] d_addr = 32'h0;
   logic [31:0] d_wdata = 32'h0;
   logic [31:0] d_rdata;
   logic        d_ack;
   logic        ram_wen;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_busy = 1'b0;
   logic        gnt_d;

   ru_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .ram_busy(ram_busy), .gnt_d(gnt_d)
   );

   always #5 clk = ~clk;

   // RAM model: 64 words, combinational read, write accepted when not busy.
   logic [31:0] mem [0:63];
   logic        pre_en = 1'b0;
   logic [5:0]  pre_idx = 6'd0;
   logic [31:0] pre_val = 32'h0;
   assign ram_rdata = mem[ram_addr[7:2]];
   always @(posedge clk) begin
      if (pre_en) mem[pre_idx] <= pre_val;
      else if (ram_wen && !ram_busy) mem[ram_addr[7:2]] <= ram_wdata;
   end

   int n_chk = 0, n_err = 0;
   int cyc = 0, i_ack_cnt = 0, d_ack_cnt = 0, i_ack_cyc = 0, d_ack_cyc = 0;
   int wen_cnt = 0, losses = 0, drivers_done = 0;
   logic [31:0] wen_addr = 32'h0, wen_data = 32'h0;
   bit rnd_on = 1'b0, f_out = 1'b0, d_out = 1'b0, d_wr = 1'b0;
   logic [31:0] f_addr = 32'h0, d_addr_c = 32'h0, d_wdata_c = 32'h0;
   logic [31:0] shadow [0:63];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Negedge observer: event counters always, transaction checks in random mode.
   task automatic monitor();
      forever begin
         @(negedge clk);
         cyc++;
         if (ram_wen) begin
            wen_cnt++; wen_addr = ram_addr; wen_data = ram_wdata;
            if (rnd_on) begin
               chk("rnd_wen_owner", 32'(d_out & d_wr), 32'd1);
               chk("rnd_wen_addr", ram_addr, d_addr_c);
               chk("rnd_wen_wdata", ram_wdata, d_wdata_c);
            end
         end
         if (i_ack) begin
            i_ack_cnt++; i_ack_cyc = cyc;
            if (rnd_on) begin
               chk("rnd_i_ack_owner", 32'(f_out), 32'd1);
               chk("rnd_i_ack_excl", 32'(d_ack), 32'd0);
               chk("rnd_i_rdata", i_rdata, shadow[f_addr[7:2]]);
               chk("rnd_starve_bound", 32'(losses <= SMAX + 1), 32'd1);
               losses = 0; f_out = 1'b0;
            end
         end
         if (d_ack) begin
            d_ack_cnt++; d_ack_cyc = cyc;
            if (rnd_on) begin
               chk("rnd_d_ack_owner", 32'(d_out), 32'd1);
               chk("rnd_d_rdata", d_rdata, shadow[d_addr_c[7:2]]);
               if (d_wr) shadow[d_addr_c[7:2]] = d_wdata_c;
               if (f_out) losses++;
               d_out = 1'b0;
            end
         end
      end
   endtask

   task automatic poke(input int idx, input logic [31:0] v);
      @(posedge clk); #1;
      pre_en = 1'b1; pre_idx = 6'(idx); pre_val = v;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic wait_ack(input bit on_d, input int base);
      int k = 0;
      if (on_d) begin
         while (d_ack_cnt <= base && k < 60) begin @(negedge clk); #1; k++; end
         chk("d_ack_seen", 32'(d_ack_cnt > base), 32'd1);
      end else begin
         while (i_ack_cnt <= base && k < 60) begin @(negedge clk); #1; k++; end
         chk("i_ack_seen", 32'(i_ack_cnt > base), 32'd1);
      end
   endtask

   task automatic check_reset(input string p);
      chk({p, "_i_ack"}, 32'(i_ack), 32'd0);
      chk({p, "_d_ack"}, 32'(d_ack), 32'd0);
      chk({p, "_i_rdata"}, i_rdata, 32'd0);
      chk({p, "_d_rdata"}, d_rdata, 32'd0);
      chk({p, "_ram_wen"}, 32'(ram_wen), 32'd0);
      chk({p, "_ram_addr"}, ram_addr, 32'd0);
      chk({p, "_ram_wdata"}, ram_wdata, 32'd0);
      chk({p, "_gnt_d"}, 32'(gnt_d), 32'd0);
   endtask

   task automatic drv_f(input int n);
      int k;
      for (int t = 0; t < n; t++) begin
         repeat ($urandom_range(0, 3) + 1) begin @(posedge clk); #1; end
         i_addr = 32'($urandom_range(0, 255)); f_addr = i_addr; f_out = 1'b1; i_req = 1'b1;
         k = 0;
         while (f_out && k < 80) begin @(negedge clk); #1; k++; end
         i_req = 1'b0;
         chk("rnd_i_done", 32'(f_out), 32'd0);
         f_out = 1'b0;
      end
      drivers_done++;
   endtask

   task automatic drv_d(input int n);
      int k, kind;
      for (int t = 0; t < n; t++) begin
         repeat ($urandom_range(0, 2) + 1) begin @(posedge clk); #1; end
         kind = int'($urandom_range(0, 2));
         d_addr = 32'($urandom_range(0, 255)); d_wdata = $urandom;
         d_addr_c = d_addr; d_wdata_c = d_wdata; d_wr = (kind != 0); d_out = 1'b1;
         d_ren = (kind != 1); d_wen = (kind != 0);
         k = 0;
         while (d_out && k < 80) begin @(negedge clk); #1; k++; end
         d_ren = 1'b0; d_wen = 1'b0;
         chk("rnd_d_done", 32'(d_out), 32'd0);
         d_out = 1'b0;
      end
      drivers_done++;
   endtask

   task automatic busy_proc();
      while (drivers_done < 2) begin
         @(posedge clk); #1;
         ram_busy = ($urandom_range(0, 3) == 0);
      end
      ram_busy = 1'b0;
   endtask

   initial begin
      int t0, bi, bd, w0;
      logic [31:0] v;
      fork monitor(); join_none
      poke(4, 32'hDEADBEEF);
      poke(5, 32'h0BADF00D);
      poke(16, 32'h5555AAAA);
      poke(2, 32'h0000000A);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); #1;
      check_reset("rst");

      // 1: fetch only
      @(posedge clk); #1;
      t0 = cyc; bi = i_ack_cnt; bd = d_ack_cnt; w0 = wen_cnt;
      i_req = 1'b1; i_addr = 32'h10;
      wait_ack(1'b0, bi); i_req = 1'b0;
      chk("t1_lat", 32'(i_ack_cyc - t0), 32'd3);
      chk("t1_rdata", i_rdata, 32'hDEADBEEF);
      chk("t1_no_wen", 32'(wen_cnt - w0), 32'd0);
      chk("t1_no_dack", 32'(d_ack_cnt - bd), 32'd0);
      chk("t1_gnt", 32'(gnt_d), 32'd0);

      // 2: write then read back
      @(posedge clk); #1;
      t0 = cyc; bd = d_ack_cnt; w0 = wen_cnt;
      d_wen = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678;
      wait_ack(1'b1, bd); d_wen = 1'b0;
      chk("t2_wr_lat", 32'(d_ack_cyc - t0), 32'd3);
      chk("t2_wen_cycles", 32'(wen_cnt - w0), 32'd1);
      chk("t2_wen_addr", wen_addr, 32'h20);
      chk("t2_wen_data", wen_data, 32'h12345678);
      chk("t2_mem", mem[8], 32'h12345678);
      chk("t2_gnt", 32'(gnt_d), 32'd1);
      @(posedge clk); #1;
      t0 = cyc; bd = d_ack_cnt;
      d_ren = 1'b1; d_addr = 32'h20;
      wait_ack(1'b1, bd); d_ren = 1'b0;
      chk("t2_rd_lat", 32'(d_ack_cyc - t0), 32'd3);
      chk("t2_rdata", d_rdata, 32'h12345678);
      chk("t2_i_hold", i_rdata, 32'hDEADBEEF);

      // 3a: simultaneous requests, data first
      @(posedge clk); #1;
      t0 = cyc; bi = i_ack_cnt; bd = d_ack_cnt;
      i_req = 1'b1; i_addr = 32'h14; d_ren = 1'b1; d_addr = 32'h20;
      wait_ack(1'b1, bd); d_ren = 1'b0;
      chk("t3_d_lat", 32'(d_ack_cyc - t0), 32'd3);
      chk("t3_i_pending", 32'(i_ack_cnt - bi), 32'd0);
      wait_ack(1'b0, bi); i_req = 1'b0;
      chk("t3_i_after_d", 32'(i_ack_cyc - d_ack_cyc), 32'd3);
      chk("t3_i_rdata", i_rdata, 32'h0BADF00D);
      // 3b: data held high continuously, fetch after STARVE_MAX data grants
      @(posedge clk); #1;
      t0 = cyc; bi = i_ack_cnt; bd = d_ack_cnt;
      i_req = 1'b1; d_ren = 1'b1;
      wait_ack(1'b0, bi); i_req = 1'b0; d_ren = 1'b0;
      chk("t3_starve_grants", 32'(d_ack_cnt - bd), 32'(SMAX));
      chk("t3_starve_lat", 32'(i_ack_cyc - t0), 32'(3 * SMAX + 3));

      // 4: busy for two ACCESS cycles during a write; late input change ignored
      @(posedge clk); #1;
      t0 = cyc; bd = d_ack_cnt; w0 = wen_cnt;
      d_wen = 1'b1; d_addr = 32'h30; d_wdata = 32'hCAFEF00D;
      @(posedge clk); #1 ram_busy = 1'b1;
      @(negedge clk); #1;
      chk("t4_wen_b1", 32'(ram_wen), 32'd1);
      chk("t4_addr_b1", ram_addr, 32'h30);
      chk("t4_wdata_b1", ram_wdata, 32'hCAFEF00D);
      @(posedge clk); #1 d_addr = 32'h3C; d_wdata = 32'h99999999;
      @(negedge clk); #1;
      chk("t4_wen_b2", 32'(ram_wen), 32'd1);
      chk("t4_addr_b2", ram_addr, 32'h30);
      chk("t4_wdata_b2", ram_wdata, 32'hCAFEF00D);
      @(posedge clk); #1 ram_busy = 1'b0;
      wait_ack(1'b1, bd); d_wen = 1'b0;
      chk("t4_lat", 32'(d_ack_cyc - t0), 32'd5);
      chk("t4_wen_cycles", 32'(wen_cnt - w0), 32'd3);
      chk("t4_mem", mem[12], 32'hCAFEF00D);
      chk("t4_mem_other", mem[15] === 32'h99999999 ? 32'd1 : 32'd0, 32'd0);

      // 5: reset during an ACCESS write
      @(posedge clk); #1;
      bd = d_ack_cnt;
      d_wen = 1'b1; d_addr = 32'h40; d_wdata = 32'h11112222;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk); #1;
      chk("t5_wen_in_rst", 32'(ram_wen), 32'd0);
      @(posedge clk); #1 rst = 1'b0; d_wen = 1'b0;
      @(negedge clk); #1;
      check_reset("t5");
      repeat (4) begin @(negedge clk); #1; end
      chk("t5_no_ack", 32'(d_ack_cnt - bd), 32'd0);
      chk("t5_mem", mem[16], 32'h5555AAAA);

      // 6: read+write together returns the old word
      @(posedge clk); #1;
      bd = d_ack_cnt;
      d_ren = 1'b1; d_wen = 1'b1; d_addr = 32'h8; d_wdata = 32'hB;
      wait_ack(1'b1, bd); d_ren = 1'b0; d_wen = 1'b0;
      chk("t6_old", d_rdata, 32'hA);
      chk("t6_mem", mem[2], 32'hB);
      @(posedge clk); #1;
      bd = d_ack_cnt;
      d_ren = 1'b1; d_addr = 32'h8;
      wait_ack(1'b1, bd); d_ren = 1'b0;
      chk("t6_new", d_rdata, 32'hB);

      // Randomized traffic against the shadow memory
      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         poke(i, v);
         shadow[i] = v;
      end
      losses = 0; drivers_done = 0; rnd_on = 1'b1;
      fork
         drv_f(40);
         drv_d(60);
         busy_proc();
      join
      repeat (3) @(posedge clk);
      rnd_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
